// File: rtl/modbus_crc_arbiter.sv
// modbus_crc_arbiter
//   Round-robin arbiter and sequencer for the shared Modbus CRC-16 engine.
//   Port 0 is receive-frame checking and port 1 is response generation.
//   For each granted request the block does four things. It clears the
//   engine. It streams the latched bytes first-byte-first, one per cycle.
//   It captures the engine result. It then pulses the owner's done strobe.
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   rX_req/rX_len/rX_data    : request level, byte count, right-aligned bytes
//   rX_gnt/rX_done/rX_crc    : grant pulse, completion pulse, held result
//   busy                     : block not in IDLE
//   crc_en/crc_clr/crc_data  : engine byte strobe, clear, byte input
//   crc_out                  : engine result (valid the cycle after crc_en)
module modbus_crc_arbiter #(
    parameter int MAX_BYTES = 11,
    parameter int LEN_W     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   r0_req,
    input  logic [LEN_W-1:0]       r0_len,
    input  logic [8*MAX_BYTES-1:0] r0_data,
    output logic                   r0_gnt,
    output logic                   r0_done,
    output logic [15:0]            r0_crc,
    input  logic                   r1_req,
    input  logic [LEN_W-1:0]       r1_len,
    input  logic [8*MAX_BYTES-1:0] r1_data,
    output logic                   r1_gnt,
    output logic                   r1_done,
    output logic [15:0]            r1_crc,
    output logic                   busy,
    output logic                   crc_en,
    output logic                   crc_clr,
    output logic [7:0]             crc_data,
    input  logic [15:0]            crc_out
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CLR  = 3'd1;
    localparam logic [2:0] S_FEED = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_BYTES);
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    logic [2:0]             state_q, state_d;
    logic [LEN_W-1:0]       idx_q, idx_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [8*MAX_BYTES-1:0] data_q, data_d;
    logic                   owner_q, owner_d;
    // 1 means port 1 was served last, so port 0 wins the next tie
    logic                   last_q, last_d;
    logic                   r0_gnt_q, r0_gnt_d, r1_gnt_q, r1_gnt_d;
    logic                   r0_done_q, r0_done_d, r1_done_q, r1_done_d;
    logic [15:0]            r0_crc_q, r0_crc_d, r1_crc_q, r1_crc_d;
    logic                   busy_q, busy_d;
    logic                   crc_en_q, crc_en_d, crc_clr_q, crc_clr_d;
    logic [7:0]             crc_data_q, crc_data_d;
    logic                   grant0_s, grant1_s;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (len > LEN_MAX) begin
            return LEN_MAX;
        end else begin
            return len;
        end
    endfunction

    // Byte idx of a right-aligned vector lives at [8*(len-idx)-1 -: 8]
    function automatic logic [7:0] byte_at(input logic [8*MAX_BYTES-1:0] data,
                                           input logic [LEN_W-1:0] len,
                                           input logic [LEN_W-1:0] idx);
        logic [LEN_W-1:0]       pos;
        logic [8*MAX_BYTES-1:0] shifted;
        pos     = len - idx - LEN_ONE;
        shifted = data >> {pos, 3'b000};
        return shifted[7:0];
    endfunction

    assign grant0_s = r0_req & (~r1_req | last_q);
    assign grant1_s = r1_req & (~r0_req | ~last_q);

    // Next-state and next-output logic; outputs are registered from the _d values
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        data_d     = data_q;
        owner_d    = owner_q;
        last_d     = last_q;
        r0_crc_d   = r0_crc_q;
        r1_crc_d   = r1_crc_q;
        r0_gnt_d   = 1'b0;
        r1_gnt_d   = 1'b0;
        r0_done_d  = 1'b0;
        r1_done_d  = 1'b0;
        crc_en_d   = 1'b0;
        crc_clr_d  = 1'b0;
        crc_data_d = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (grant0_s) begin
                    owner_d   = 1'b0;
                    last_d    = 1'b0;
                    len_d     = clamp_len(r0_len);
                    data_d    = r0_data;
                    idx_d     = LEN_ZERO;
                    r0_gnt_d  = 1'b1;
                    crc_clr_d = 1'b1;
                    state_d   = S_CLR;
                end else if (grant1_s) begin
                    owner_d   = 1'b1;
                    last_d    = 1'b1;
                    len_d     = clamp_len(r1_len);
                    data_d    = r1_data;
                    idx_d     = LEN_ZERO;
                    r1_gnt_d  = 1'b1;
                    crc_clr_d = 1'b1;
                    state_d   = S_CLR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLR: begin
                idx_d = LEN_ZERO;
                if (len_q == LEN_ZERO) begin
                    state_d = S_WAIT;
                end else begin
                    state_d    = S_FEED;
                    crc_en_d   = 1'b1;
                    crc_data_d = byte_at(data_q, len_q, LEN_ZERO);
                end
            end
            S_FEED: begin
                // idx_q is the byte currently on crc_data
                if (idx_q == len_q - LEN_ONE) begin
                    state_d = S_WAIT;
                end else begin
                    idx_d      = idx_q + LEN_ONE;
                    crc_en_d   = 1'b1;
                    crc_data_d = byte_at(data_q, len_q, idx_q + LEN_ONE);
                end
            end
            S_WAIT: begin
                // Engine has absorbed the last byte by now
                if (owner_q) begin
                    r1_crc_d  = crc_out;
                    r1_done_d = 1'b1;
                end else begin
                    r0_crc_d  = crc_out;
                    r0_done_d = 1'b1;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= LEN_ZERO;
            len_q      <= LEN_ZERO;
            data_q     <= {(8*MAX_BYTES){1'b0}};
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            r0_gnt_q   <= 1'b0;
            r1_gnt_q   <= 1'b0;
            r0_done_q  <= 1'b0;
            r1_done_q  <= 1'b0;
            r0_crc_q   <= 16'h0000;
            r1_crc_q   <= 16'h0000;
            busy_q     <= 1'b0;
            crc_en_q   <= 1'b0;
            crc_clr_q  <= 1'b0;
            crc_data_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            data_q     <= data_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            r0_gnt_q   <= r0_gnt_d;
            r1_gnt_q   <= r1_gnt_d;
            r0_done_q  <= r0_done_d;
            r1_done_q  <= r1_done_d;
            r0_crc_q   <= r0_crc_d;
            r1_crc_q   <= r1_crc_d;
            busy_q     <= busy_d;
            crc_en_q   <= crc_en_d;
            crc_clr_q  <= crc_clr_d;
            crc_data_q <= crc_data_d;
        end
    end

    assign r0_gnt   = r0_gnt_q;
    assign r1_gnt   = r1_gnt_q;
    assign r0_done  = r0_done_q;
    assign r1_done  = r1_done_q;
    assign r0_crc   = r0_crc_q;
    assign r1_crc   = r1_crc_q;
    assign busy     = busy_q;
    assign crc_en   = crc_en_q;
    assign crc_clr  = crc_clr_q;
    assign crc_data = crc_data_q;

endmodule

// File: tb/tb_modbus_crc_arbiter.sv
// Bench for modbus_crc_arbiter: models the CRC-16 engine, keeps a scoreboard
// of expected completions (port, CRC, byte count) and checks them as done
// pulses appear, together with grant/done exclusivity and cycle timing.
module tb_modbus_crc_arbiter;

    localparam int MAX_BYTES = 11;
    localparam int LEN_W     = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   r0_req, r1_req;
    logic [LEN_W-1:0]       r0_len, r1_len;
    logic [8*MAX_BYTES-1:0] r0_data, r1_data;
    logic                   r0_gnt, r0_done, r1_gnt, r1_done;
    logic [15:0]            r0_crc, r1_crc;
    logic                   busy, crc_en, crc_clr;
    logic [7:0]             crc_data;
    logic [15:0]            crc_out;

    typedef struct {
        logic        port;
        logic [15:0] crc;
        int          nbytes;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          gnt_cyc  = 0;
    int          en_cnt   = 0;
    logic [15:0] exp_last[2];
    logic [15:0] eng_crc;

    modbus_crc_arbiter #(.MAX_BYTES(MAX_BYTES), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_len(r0_len), .r0_data(r0_data),
        .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_crc(r0_crc),
        .r1_req(r1_req), .r1_len(r1_len), .r1_data(r1_data),
        .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_crc(r1_crc),
        .busy(busy), .crc_en(crc_en), .crc_clr(crc_clr),
        .crc_data(crc_data), .crc_out(crc_out)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int k = 0; k < 8; k++) begin
            if (r[0]) r = (r >> 1) ^ 16'hA001;
            else      r = r >> 1;
        end
        return r;
    endfunction

    function automatic logic [15:0] crc_of(input logic [8*MAX_BYTES-1:0] d, input int n);
        logic [15:0]            c;
        logic [8*MAX_BYTES-1:0] s;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            s = d >> (8 * (n - 1 - i));
            c = crc_step(c, s[7:0]);
        end
        return c;
    endfunction

    // CRC engine model: clear to FFFF, one byte per crc_en, result next cycle
    always @(posedge clk) begin
        if (rst)          eng_crc <= 16'h0000;
        else if (crc_clr) eng_crc <= 16'hFFFF;
        else if (crc_en)  eng_crc <= crc_step(eng_crc, crc_data);
    end
    assign crc_out = eng_crc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: exclusivity, per-transaction timing and scoreboard compare
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            sb.delete();
            exp_last[0] = 16'h0000;
            exp_last[1] = 16'h0000;
            en_cnt      = 0;
        end else begin
            if (r0_gnt || r1_gnt) begin
                check_eq("gnt_excl", {63'd0, r0_gnt & r1_gnt}, 64'd0);
                check_eq("clr_at_gnt", {63'd0, crc_clr}, 64'd1);
                gnt_cyc = cyc;
                en_cnt  = 0;
            end
            if (crc_en) begin
                en_cnt++;
                check_eq("clr_en_excl", {63'd0, crc_clr}, 64'd0);
            end
            if (r0_done || r1_done) begin
                check_eq("done_excl", {63'd0, r0_done & r1_done}, 64'd0);
                if (sb.size() == 0) begin
                    check_eq("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    logic p;
                    e = sb.pop_front();
                    p = r1_done;
                    check_eq("done_port", {63'd0, p}, {63'd0, e.port});
                    check_eq("crc", p ? r1_crc : r0_crc, e.crc);
                    check_eq("other_crc_hold", p ? r0_crc : r1_crc, exp_last[~p]);
                    check_eq("en_count", en_cnt, e.nbytes);
                    check_eq("done_latency", cyc - gnt_cyc, e.nbytes + 2);
                    exp_last[p] = e.crc;
                end
            end
        end
    end

    task automatic push_exp(input logic p, input logic [15:0] c, input int n);
        exp_t e;
        e.port = p; e.crc = c; e.nbytes = n;
        sb.push_back(e);
    endtask

    task automatic check_zero(input string tag);
        check_eq(tag, {r0_gnt, r0_done, r0_crc, r1_gnt, r1_done, r1_crc,
                       busy, crc_en, crc_clr, crc_data}, 64'd0);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) ok = 1'b1;
        end
        check_eq("idle_reached", {63'd0, ok}, 64'd1);
    endtask

    // Single request from an idle block: grant must follow one cycle later
    task automatic single(input logic p, input logic [LEN_W-1:0] len,
                          input logic [8*MAX_BYTES-1:0] d, input logic [15:0] c, input int n);
        push_exp(p, c, n);
        if (p) begin r1_req = 1'b1; r1_len = len; r1_data = d; end
        else   begin r0_req = 1'b1; r0_len = len; r0_data = d; end
        @(negedge clk);
        check_eq("gnt_latency", {63'd0, p ? r1_gnt : r0_gnt}, 64'd1);
        r0_req = 1'b0;
        r1_req = 1'b0;
        wait_idle();
    endtask

    // Hold requests until n grants seen; optionally drop each port on its grant
    task automatic hold_grants(input int n, input bit drop_each);
        int seen = 0;
        for (int i = 0; i < 400 && seen < n; i++) begin
            @(negedge clk);
            if (r0_gnt) begin seen++; if (drop_each) r0_req = 1'b0; end
            if (r1_gnt) begin seen++; if (drop_each) r1_req = 1'b0; end
        end
        r0_req = 1'b0;
        r1_req = 1'b0;
        check_eq("grant_count", seen, n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset_outputs");
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [95:0] rnd;
        int          n;
        logic        p;
        rst = 1'b1;
        r0_req = 1'b0; r1_req = 1'b0;
        r0_len = '0;   r1_len = '0;
        r0_data = '0;  r1_data = '0;
        @(negedge clk);
        do_reset();

        // Port 0 read request, port 1 exception response
        single(1'b0, 4'd6, 88'h010300000001, 16'h0A84, 6);
        single(1'b1, 4'd3, 88'h018302, 16'hF1C0, 3);

        // Tie after reset: port 0 first, then port 1
        do_reset();
        push_exp(1'b0, 16'h0B98, 6);
        push_exp(1'b1, 16'hF1C0, 3);
        r0_len = 4'd6; r0_data = 88'h010600010003;
        r1_len = 4'd3; r1_data = 88'h018302;
        r0_req = 1'b1; r1_req = 1'b1;
        hold_grants(2, 1'b1);
        wait_idle();

        // Fairness with both requests held continuously
        for (int k = 0; k < 2; k++) begin
            push_exp(1'b0, 16'h0B98, 6);
            push_exp(1'b1, 16'hF1C0, 3);
        end
        r0_req = 1'b1; r1_req = 1'b1;
        hold_grants(4, 1'b0);
        wait_idle();

        // Length edges: empty request and an over-long length clamped to MAX_BYTES
        single(1'b0, 4'd0, 88'h0, 16'hFFFF, 0);
        single(1'b1, 4'd15, 88'h0102030405060708090A0B,
               crc_of(88'h0102030405060708090A0B, 11), 11);

        // Reset during the third FEED cycle abandons the transaction
        push_exp(1'b0, 16'h0A84, 6);
        r0_req = 1'b1; r0_len = 4'd6; r0_data = 88'h010300000001;
        @(negedge clk);
        check_eq("gnt_before_rst", {63'd0, r0_gnt}, 64'd1);
        r0_req = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("feed3_en", {63'd0, crc_en}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_zero("mid_feed_reset");
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("no_busy_after_rst", {63'd0, busy}, 64'd0);
        single(1'b0, 4'd6, 88'h010300000001, 16'h0A84, 6);

        // A few pseudo-random frames; bytes above the length must be ignored
        for (int k = 0; k < 4; k++) begin
            rnd = {$urandom, $urandom, $urandom};
            n   = $urandom_range(1, MAX_BYTES);
            p   = 1'($urandom_range(0, 1));
            single(p, LEN_W'(n), rnd[87:0], crc_of(rnd[87:0], n), n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/modbus_crc_arbiter.md
# modbus_crc_arbiter

Round-robin arbiter and sequencer for the single shared `crc_16` engine in the Modbus RTU slave. It serves two requesters: port 0 is receive-frame CRC checking, port 1 is response CRC generation. For each granted request it clears the engine, streams the requester's byte vector MSB-first one byte per cycle, waits for the engine result and returns the CRC. Two frame paths can therefore share one engine without ad-hoc `byte_cnt`/`crc_clr` sequencing in each client.

## Interface

**Parameters**
- `MAX_BYTES`, default 11: maximum bytes per request (longest checked frame).
- `LEN_W`, default 4: width of length fields; must satisfy `2**LEN_W > MAX_BYTES`.

**Ports**
- `clk`  in  1  — single clock for the block.
- `rst`  in  1  — synchronous, active-high reset.
- `r0_req`  in  1  — port 0 request (level).
- `r0_len`  in  LEN_W  — port 0 byte count.
- `r0_data`  in  8*MAX_BYTES  — port 0 bytes, right-aligned; first byte at `[8*len-1 -: 8]`.
- `r0_gnt`  out  1  — 1-cycle pulse: port 0 inputs sampled.
- `r0_done`  out  1  — 1-cycle pulse: `r0_crc` valid.
- `r0_crc`  out  16  — port 0 result; holds until the next port 0 completion.
- `r1_req`, `r1_len`, `r1_data`, `r1_gnt`, `r1_done`, `r1_crc` — same definitions for port 1.
- `busy`  out  1  — high in any state other than IDLE.
- `crc_en`  out  1  — engine byte strobe.
- `crc_clr`  out  1  — engine clear; sets the CRC to `16'hFFFF`.
- `crc_data`  out  8  — engine byte input.
- `crc_out`  in  16  — engine result; updates the cycle after a `crc_en` cycle.

## Operation

**States:** IDLE → CLR → FEED → WAIT → DONE → IDLE. All outputs are registered.

- **IDLE**
  - If no request is pending, stay in IDLE.
  - If exactly one `rX_req` is high, grant that port.
  - If both are high, grant the port not served last. The last-served pointer resets to "port 1", so port 0 wins the first tie.
  - On grant:
    - Latch `rX_data` and `rX_len`. A length above MAX_BYTES is clamped to MAX_BYTES.
    - Record the owner and update the last-served pointer.
    - Pulse `rX_gnt` and go to CLR.
- **CLR**
  - `crc_clr`=1 for one cycle.
  - Byte index `idx`=0.
  - If the latched length is 0, go to WAIT; otherwise go to FEED.
- **FEED**
  - `crc_en`=1 and `crc_data` = latched byte `idx`, where byte `idx` is `data[8*(len-idx)-1 -: 8]`.
  - `idx` increments each cycle.
  - When `idx`==len-1, go to WAIT.
- **WAIT**
  - `crc_en`=0.
  - Latch `crc_out` into the owner's `rX_crc`.
  - Go to DONE.
- **DONE**
  - Pulse the owner's `rX_done`.
  - Return to IDLE. New requests are evaluated starting with the IDLE cycle.

**Request rules**
- A requester holds `rX_req` until it sees `rX_gnt`. Its data may change after `rX_gnt`.
- If `rX_req` is still high after the grant cycle, it is treated as a new request and arbitrated again after DONE.
- A request arriving while `busy` waits and is never lost.
- Only the owner's `rX_crc` changes. The other port's result holds.

**Reset**
- All outputs go to 0, including `rX_crc`=0.
- State = IDLE, `idx`=0, pointer = port 1.
- Reset mid-transaction abandons it: no `done` is issued for it. The requester must re-request.

## Timing

- **Grant latency:** `rX_req` sampled high in IDLE at edge t → `rX_gnt`=1 and `crc_clr`=1 during cycle t+1.
- **Feed:** `crc_en` is high for cycles t+2 … t+1+len, one byte per cycle, no bubbles.
- **Result:** WAIT in cycle t+2+len; `rX_done` high in cycle t+3+len, with `rX_crc` valid that same cycle.
- **Total:** len+3 cycles from req sample to done. Back-to-back transactions are separated by one IDLE cycle.
- **Length 0:** done at t+3, `crc` = `16'hFFFF`.
- `crc_clr` and `crc_en` are never high in the same cycle.
- `r0_gnt` and `r1_gnt` are never high together. The same holds for `done`.

## Test plan

- **Port 0 only:** `r0_data`=`01 03 00 00 00 01`, len 6 → `r0_gnt` 1 cycle later, 6 `crc_en` cycles, `r0_done` at +9 with `r0_crc`=`16'h0A84`.
- **Port 1 exception response:** `01 83 02`, len 3 → `r1_done` at +6, `r1_crc`=`16'hF1C0`.
- **Simultaneous requests after reset:** `r0`=`01 06 00 01 00 03`, `r1`=`01 83 02`, both held → port 0 served first (`16'h0B98`), then port 1 (`16'hF1C0`). `r0_crc` is unchanged during port 1's run.
- **Fairness:** both requests held high continuously for 4 transactions → grants alternate 0,1,0,1. No two gnt or done pulses overlap.
- **Length edge cases:** len 0 → `crc`=`16'hFFFF` at +3. len 15 with MAX_BYTES=11 → exactly 11 `crc_en` cycles.
- **Reset mid-FEED:** `rst` in the 3rd FEED cycle → next cycle all outputs 0 and state IDLE, no `done` pulse. A re-request completes correctly.
